// File: rtl/rle_pkg.sv
// rle_pkg: shared run-length word layout for the RLE encoder/decoder pair.
package rle_pkg;

  localparam int unsigned RLE_CW = 8;
  localparam int unsigned RLE_DW = 8;

  // Compressed word: run counter above the data byte
  typedef struct packed {
    logic [RLE_CW-1:0] cnt;
    logic [RLE_DW-1:0] dat;
  } rle_word_t;

  // Number of output samples a word expands to
  function automatic int rle_len(input logic [RLE_CW-1:0] cnt);
    return int'(cnt) + 1;
  endfunction

endpackage

// File: rtl/rld.sv
// rld: run-length decoder. Each input word {cnt, dat} expands to cnt+1 copies
// of dat; with cfg_ena=0 the cnt field is ignored (one output per input).
// Optional feature macro RLD_STAT_EN adds the sts_cnt emitted-sample counter.
module rld
  import rle_pkg::*;
#(
  parameter int unsigned CW = RLE_CW,
  parameter int unsigned DN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CW+RLE_DW-1:0] sti_tdata,
  input  logic               sti_tvalid,
  input  logic               sti_tlast,
  output logic               sti_tready,
  output logic [RLE_DW-1:0]  sto_tdata,
  output logic               sto_tvalid,
  output logic               sto_tlast,
  input  logic               sto_tready,
  output logic [DN-1:0]      sto_tkeep,
  input  logic               ctl_rst,
  input  logic               cfg_ena
`ifdef RLD_STAT_EN
  ,output logic [31:0]       sts_cnt
`endif
);

  logic [RLE_DW-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              lst_q, lst_d;
  logic [CW-1:0]     rem_q, rem_d;

  logic [CW-1:0]     in_cnt_c;
  logic [RLE_DW-1:0] in_dat_c;
  logic              adv_c;
  logic              run_c;
  logic              in_xfer_c;
  logic              clr_c;

  assign in_cnt_c  = sti_tdata[CW+RLE_DW-1:RLE_DW];
  assign in_dat_c  = sti_tdata[RLE_DW-1:0];
  assign clr_c     = rst | ctl_rst;
  assign adv_c     = sto_tready | ~valid_q;
  assign run_c     = (rem_q != '0);
  assign sti_tready = adv_c & ~run_c;
  assign in_xfer_c = sti_tvalid & sti_tready;

  assign sto_tdata  = data_q;
  assign sto_tvalid = valid_q;
  assign sto_tlast  = last_q;
  assign sto_tkeep  = '1;

  // Next state: load a new word, repeat the held word, or drain the output
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    lst_d   = lst_q;
    rem_d   = rem_q;
    if (in_xfer_c) begin
      data_d  = in_dat_c;
      valid_d = 1'b1;
      rem_d   = cfg_ena ? in_cnt_c : '0;
      lst_d   = sti_tlast;
      last_d  = sti_tlast & (~cfg_ena | (in_cnt_c == '0));
    end else if (run_c && adv_c) begin
      valid_d = 1'b1;
      rem_d   = rem_q - CW'(1);
      last_d  = lst_q & (rem_q == CW'(1));
    end else if (adv_c) begin
      valid_d = 1'b0;
    end
  end

  // Output stage and run state registers
  always_ff @(posedge clk) begin
    if (clr_c) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lst_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      lst_q   <= lst_d;
      rem_q   <= rem_d;
    end
  end

`ifdef RLD_STAT_EN
  logic [31:0] stat_q, stat_d;

  assign sts_cnt = stat_q;

  // Emitted-sample count, wraps naturally at 2**32
  always_comb begin
    stat_d = stat_q + 32'(valid_q & sto_tready);
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (clr_c) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end
`endif

endmodule
